// File: rtl/shift_pkg.sv
// shift_pkg: request type, port/direction encodings and helpers shared by the shift unit arbiter
package shift_pkg;
   localparam int REQ_TAG_W = 4;
   localparam int PORT_ALU  = 0;
   localparam int PORT_LSU  = 1;
   localparam bit DIR_LEFT  = 1'b1;
   localparam bit DIR_RIGHT = 1'b0;
   typedef struct packed {
      logic [31:0]          data;
      logic [4:0]           amt;
      logic                 dir;
      logic                 arith;
      logic [REQ_TAG_W-1:0] tag;
   } shift_req_t;
   function automatic logic [31:0] bit_rev(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction
endpackage

// File: rtl/barrel_shifter_32.sv
// barrel_shifter_32: combinational 32-bit shifter, left shifts done as reversed right shifts
module barrel_shifter_32
   import shift_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [4:0]  i_amt,
   input  logic        i_dir,
   input  logic        i_arith,
   output logic [31:0] o_data
);
   logic             w_fill;
   logic [5:0][31:0] w_stage;
   assign w_fill     = (i_dir == DIR_RIGHT) && i_arith && i_data[31];
   assign w_stage[0] = (i_dir == DIR_LEFT) ? bit_rev(i_data) : i_data;
   for (genvar k = 0; k < 5; k++) begin : g_stage
      localparam int S = 1 << k;
      assign w_stage[k+1] = i_amt[k] ? {{S{w_fill}}, w_stage[k][31:S]} : w_stage[k];
   end
   assign o_data = (i_dir == DIR_LEFT) ? bit_rev(w_stage[5]) : w_stage[5];
endmodule

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-request arbiter, round-robin or fixed priority, grants only while enabled
module rr_arbiter_2 #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   logic r_prio;
   logic w_pri;
   assign w_pri    = FIXED_PRIO ? 1'b0 : r_prio;
   assign o_gnt[0] = i_en && i_req[0] && (!i_req[1] || !w_pri);
   assign o_gnt[1] = i_en && i_req[1] && (!i_req[0] || w_pri);
   // priority passes to the other port after every grant
   always_ff @(posedge clk) begin
      if (reset) r_prio <= 1'b0;
      else if (|o_gnt) r_prio <= o_gnt[0];
   end
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: one shared barrel shifter for ALU and LSU requesters with a registered, tagged result
module shift_unit_arbiter
   import shift_pkg::*;
#(
   parameter int TAG_W      = 4,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][31:0]      req_data,
   input  logic [1:0][4:0]       req_amt,
   input  logic [1:0]            req_dir,
   input  logic [1:0]            req_arith,
   input  logic [1:0][TAG_W-1:0] req_tag,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic                  resp_id,
   output logic [TAG_W-1:0]      resp_tag
);
   logic             w_adv;
   logic [1:0]       w_gnt;
   shift_req_t [1:0] w_req;
   shift_req_t       w_sel;
   logic [31:0]      w_shifted;
   logic             r_valid;
   logic [31:0]      r_data;
   logic             r_id;
   logic [TAG_W-1:0] r_tag;
   assign w_adv = !r_valid || resp_ready;
   always_comb begin
      for (int i = 0; i < 2; i++)
         w_req[i] = '{data: req_data[i], amt: req_amt[i], dir: req_dir[i],
                      arith: req_arith[i], tag: REQ_TAG_W'(req_tag[i])};
   end
   assign w_sel     = w_gnt[PORT_LSU] ? w_req[PORT_LSU] : w_req[PORT_ALU];
   assign req_ready = w_gnt;
   rr_arbiter_2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_adv && !reset),
      .i_req (req_valid),
      .o_gnt (w_gnt)
   );
   barrel_shifter_32 u_shift (
      .i_data  (w_sel.data),
      .i_amt   (w_sel.amt),
      .i_dir   (w_sel.dir),
      .i_arith (w_sel.arith),
      .o_data  (w_shifted)
   );
   // payload only reloads on a grant so a drained result keeps its last data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_id    <= 1'b0;
         r_tag   <= '0;
      end else if (w_adv) begin
         r_valid <= |w_gnt;
         if (|w_gnt) begin
            r_data <= w_shifted;
            r_id   <= w_gnt[PORT_LSU];
            r_tag  <= TAG_W'(w_sel.tag);
         end
      end
   end
   assign resp_valid = r_valid;
   assign resp_data  = r_data;
   assign resp_id    = r_id;
   assign resp_tag   = r_tag;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed and random checks of round-robin and fixed-priority instances against a reference model
module tb_shift_unit_arbiter;
   localparam int TW = 4;
   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 resp_ready = 1'b1;
   logic [1:0]           req_valid = '0;
   logic [1:0]           req_dir = '0;
   logic [1:0]           req_arith = '0;
   logic [1:0][31:0]     req_data = '0;
   logic [1:0][4:0]      req_amt = '0;
   logic [1:0][TW-1:0]   req_tag = '0;
   logic [1:0]           rdy [2];
   logic                 vld [2];
   logic [31:0]          dat [2];
   logic                 rid [2];
   logic [TW-1:0]        tg  [2];
   logic                 mv [2];
   logic [31:0]          md [2];
   logic                 mi [2];
   logic [TW-1:0]        mt [2];
   int                   mp [2];
   int                   total = 0;
   int                   bad = 0;
   logic [31:0]          hold_d;
   logic                 hold_i;

   always #5 clk = ~clk;

   shift_unit_arbiter #(.TAG_W(TW), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir), .req_arith(req_arith),
      .req_tag(req_tag), .resp_valid(vld[0]), .resp_ready(resp_ready),
      .resp_data(dat[0]), .resp_id(rid[0]), .resp_tag(tg[0])
   );
   shift_unit_arbiter #(.TAG_W(TW), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir), .req_arith(req_arith),
      .req_tag(req_tag), .resp_valid(vld[1]), .resp_ready(resp_ready),
      .resp_data(dat[1]), .resp_id(rid[1]), .resp_tag(tg[1])
   );

   task automatic chk(input string nm, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", nm, o, e);
      end
   endtask

   function automatic logic [31:0] ref_shift(input int p);
      logic signed [31:0] s;
      if (req_dir[p]) return req_data[p] << req_amt[p];
      if (!req_arith[p]) return req_data[p] >> req_amt[p];
      s = req_data[p];
      return s >>> req_amt[p];
   endfunction

   function automatic logic [1:0] exp_gnt(input int n);
      if (reset || !(!mv[n] || resp_ready)) return 2'b00;
      if (req_valid == 2'b11) return (n == 1 || mp[n] == 0) ? 2'b01 : 2'b10;
      return req_valid;
   endfunction

   task automatic set_req(input int p, input logic [31:0] d, input logic [4:0] a,
                          input logic dr, input logic ar, input logic [TW-1:0] t);
      req_data[p]  = d;
      req_amt[p]   = a;
      req_dir[p]   = dr;
      req_arith[p] = ar;
      req_tag[p]   = t;
   endtask

   task automatic step();
      logic [1:0] g;
      int p;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         g = exp_gnt(n);
         chk($sformatf("ready%0d", n), 64'(rdy[n]), 64'(g));
         chk($sformatf("valid%0d", n), 64'(vld[n]), 64'(mv[n]));
         chk($sformatf("data%0d", n), 64'(dat[n]), 64'(md[n]));
         chk($sformatf("id%0d", n), 64'(rid[n]), 64'(mi[n]));
         chk($sformatf("tag%0d", n), 64'(tg[n]), 64'(mt[n]));
         if (reset) begin
            mv[n] = 1'b0; md[n] = '0; mi[n] = 1'b0; mt[n] = '0; mp[n] = 0;
         end else if (!mv[n] || resp_ready) begin
            mv[n] = (g != 2'b00);
            if (g != 2'b00) begin
               p = g[1] ? 1 : 0;
               md[n] = ref_shift(p);
               mi[n] = g[1];
               mt[n] = req_tag[p];
               mp[n] = 1 - p;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         mv[n] = 1'b0; md[n] = '0; mi[n] = 1'b0; mt[n] = '0; mp[n] = 0;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      step();
      req_valid = 2'b00;
      reset = 1'b0;
      step();
      chk("reset_valid", 64'(vld[0]), 64'd0);

      set_req(0, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 4'h3);
      req_valid = 2'b01;
      step();
      chk("p0_sra", 64'(dat[0]), 64'hF800_0000);
      chk("p0_id", 64'(rid[0]), 64'd0);
      req_arith[0] = 1'b0;
      step();
      chk("p0_srl", 64'(dat[0]), 64'h0800_0000);

      set_req(1, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 4'hA);
      req_valid = 2'b10;
      step();
      chk("p1_sll", 64'(dat[0]), 64'h8000_0000);
      chk("p1_tag", 64'(tg[0]), 64'hA);
      chk("p1_id", 64'(rid[0]), 64'd1);
      set_req(1, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 4'h5);
      step();
      chk("p1_amt0", 64'(dat[0]), 64'h1234_5678);
      req_valid = 2'b00;
      step();
      chk("drain_valid", 64'(vld[0]), 64'd0);
      chk("drain_data", 64'(dat[0]), 64'h1234_5678);

      set_req(0, 32'h0000_00F0, 5'd2, 1'b1, 1'b0, 4'h1);
      set_req(1, 32'hF000_0000, 5'd8, 1'b0, 1'b1, 4'h2);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant", 64'(rdy[0]), (i % 2) ? 64'd2 : 64'd1);
         chk("fp_grant", 64'(rdy[1]), 64'd1);
         step();
         chk("rr_id", 64'(rid[0]), 64'(i % 2));
         chk("rr_nobubble", 64'(vld[0]), 64'd1);
         chk("fp_id", 64'(rid[1]), 64'd0);
      end

      resp_ready = 1'b0;
      hold_d = dat[0];
      hold_i = rid[0];
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 64'(rdy[0]), 64'd0);
         step();
         chk("bp_valid", 64'(vld[0]), 64'd1);
         chk("bp_data", 64'(dat[0]), 64'(hold_d));
         chk("bp_id", 64'(rid[0]), 64'(hold_i));
      end
      resp_ready = 1'b1;
      step();
      chk("release_id", 64'(rid[0]), 64'd0);
      chk("release_valid", 64'(vld[0]), 64'd1);

      resp_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_ready", 64'(rdy[0]), 64'd0);
      step();
      chk("rst_valid", 64'(vld[0]), 64'd0);
      reset = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("rst_first_grant", 64'(rdy[0]), 64'd1);
      step();
      chk("rst_first_id", 64'(rid[0]), 64'd0);

      repeat (400) begin
         req_valid = 2'($urandom);
         for (int p = 0; p < 2; p++)
            set_req(p, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), TW'($urandom));
         resp_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 49) == 0);
         step();
      end
      reset = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
